dnn_argmax_fix: RTL and testbench
=================================

Name: dnn_argmax_fix

Overview:
Classification stage directly downstream of the fixed-point ReLU inference engine. It watches the engine's done level and latches the 10 signed output scores on its rising edge. It then scans the scores serially, one per cycle, and reports the winning digit, the winning score, and the top-1/top-2 margin over a valid/ready handshake. This is the last stage before the result leaves the accelerator.

Parameters:
DATA_WIDTH, 14, signed score width (must match the engine's DATA_WIDTH)
NUM_CLASSES, 10, number of scores scanned
IDX_WIDTH, 4, width of the class index (>= clog2(NUM_CLASSES))

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous soft clear, active-high
scores_done  input  1  engine done level; a rising edge means scores are valid
scores  input  DATA_WIDTH x NUM_CLASSES  signed engine outputs, index 0..9
busy  output  1  high while in SCAN or HOLD
result_valid  output  1  result available
result_ready  input  1  consumer accepts the result
class_idx  output  IDX_WIDTH  winning class
class_score  output  DATA_WIDTH  signed winning score
margin  output  DATA_WIDTH+1  unsigned, best minus second-best

Behaviour:
- Reset (rst=0, async) and clear=1 (sync) have identical effect:
  - state=IDLE; edge-detect register done_q=0.
  - All outputs 0: busy, result_valid, class_idx, class_score, margin.
  - clear takes priority over every other event in the same cycle.
- Edge detect: start_evt = scores_done & ~done_q; done_q registers scores_done every cycle in every state.
- IDLE, on start_evt:
  - Copy all scores into an internal array.
  - idx<=0; best<=most negative value; second<=most negative value; best_idx<=0.
  - Go to SCAN.
- SCAN: each cycle process s=array[idx]:
  - If s > best: second<=best, best<=s, best_idx<=idx.
  - Else if s > second: second<=s.
  - Comparisons are strict signed compares, so ties keep the lowest index.
  - An equal top score moves into second, which gives margin 0.
  - idx increments; after processing idx=NUM_CLASSES-1, go to HOLD.
- HOLD:
  - result_valid=1; class_idx, class_score and margin are registered and stable.
  - margin = best - second, computed at DATA_WIDTH+1 bits unsigned; it cannot overflow (max 2^DATA_WIDTH - 1).
  - Result transfers on result_valid & result_ready; next cycle go to IDLE with result_valid=0.
  - class_idx, class_score and margin keep their last values in IDLE.
- Latency: start_evt sampled at edge T → SCAN during T+1..T+10 → result_valid=1 from edge T+11.
  - With result_ready held high, the transfer occurs in cycle T+11.
  - Minimum spacing between results is 12 cycles.
- start_evt in SCAN or HOLD is ignored. The scores are not re-captured and the scan in progress is unaffected. done_q still tracks, so a level that is still high afterwards does not retrigger.
- start_evt in the same cycle as the HOLD→IDLE transfer is ignored; the engine must re-pulse done.
- busy = (state != IDLE).
- The scores input is sampled only at capture. Later changes do not affect the result.

Decomposition:
- Shared package dnn_fix_pkg holds:
  - localparams DNN_DATA_WIDTH=14 and DNN_NUM_CLASSES=10.
  - typedef score_t (signed [DNN_DATA_WIDTH-1:0]).
  - enum argmax_state_t {IDLE, SCAN, HOLD}.
  - constant SCORE_MIN (most negative score_t).
- One combinational sub-module, dnn_top2_update: inputs s, best, second, best_idx, idx; outputs next best, second and best_idx. It is reused by any later top-k stage.
- All registers stay in dnn_argmax_fix.

Test Plan:
- Distinct scores {10,-5,300,7,299,0,1,2,3,4}, ready=1 → class_idx=2, class_score=300, margin=1, result_valid at T+11 for one cycle.
- All negative {-100,-90,-80,-8192,-70,-60,-75,-61,-200,-65} → class_idx=5, class_score=-60, margin=1.
- Tie {0,50,50,...,0}, and all-equal 123 → first gives class_idx=1, margin=0; second gives class_idx=0, margin=0.
- Extremes: score[9]=8191, all others -8192 → class_idx=9, class_score=8191, margin=16383.
- Backpressure: result_ready=0 for 20 cycles after valid, plus a second done pulse during HOLD → outputs stable and second pulse ignored; ready=1 transfers once, then IDLE.
- clear=1 at T+5, then async rst=0 mid-SCAN on a fresh run → both return IDLE with all outputs 0 immediately (rst asynchronously); a fresh done edge then yields the correct result at +11.

Source files
------------

// File: rtl/dnn_argmax_fix_pkg.sv
// Shared types and constants for the fixed-point DNN classification stages.
package dnn_fix_pkg;

    // Must track the inference engine's output format.
    localparam int unsigned DNN_DATA_WIDTH  = 14;
    localparam int unsigned DNN_NUM_CLASSES = 10;
    localparam int unsigned DNN_IDX_WIDTH   = 4;

    typedef logic signed [DNN_DATA_WIDTH-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } argmax_state_t;

    // Most negative representable score; seeds the best/second trackers.
    localparam score_t SCORE_MIN = {1'b1, {(DNN_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/dnn_argmax_fix_if.sv
// Score capture and result handshake bundle between engine, argmax and consumer.
interface dnn_argmax_fix_if
    import dnn_fix_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DNN_DATA_WIDTH,
    parameter int unsigned NUM_CLASSES = DNN_NUM_CLASSES,
    parameter int unsigned IDX_WIDTH   = DNN_IDX_WIDTH
);

    // Engine side
    logic                                  clear;
    logic                                  scores_done;
    logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] scores;

    // Result side
    logic                                  busy;
    logic                                  result_valid;
    logic                                  result_ready;
    logic [IDX_WIDTH-1:0]                  class_idx;
    logic [DATA_WIDTH-1:0]                 class_score;
    logic [DATA_WIDTH:0]                   margin;

    // Drives the argmax: engine plus result consumer.
    modport master (
        output clear,
        output scores_done,
        output scores,
        output result_ready,
        input  busy,
        input  result_valid,
        input  class_idx,
        input  class_score,
        input  margin
    );

    // The argmax block itself.
    modport slave (
        input  clear,
        input  scores_done,
        input  scores,
        input  result_ready,
        output busy,
        output result_valid,
        output class_idx,
        output class_score,
        output margin
    );

endinterface

// File: rtl/dnn_top2_update.sv
// Combinational top-2 tracker step: folds one score into the running best/second pair.
module dnn_top2_update #(
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned IDX_WIDTH  = 4
) (
    input  logic signed [DATA_WIDTH-1:0] s,
    input  logic signed [DATA_WIDTH-1:0] best,
    input  logic signed [DATA_WIDTH-1:0] second,
    input  logic        [IDX_WIDTH-1:0]  best_idx,
    input  logic        [IDX_WIDTH-1:0]  idx,
    output logic signed [DATA_WIDTH-1:0] best_next,
    output logic signed [DATA_WIDTH-1:0] second_next,
    output logic        [IDX_WIDTH-1:0]  best_idx_next
);

    // Strict compares: an equal score never displaces the earlier index but
    // does become the runner-up, which yields a zero margin on ties.
    always_comb begin
        best_next     = best;
        second_next   = second;
        best_idx_next = best_idx;
        if (s > best) begin
            second_next   = best;
            best_next     = s;
            best_idx_next = idx;
        end else if (s > second) begin
            second_next = s;
        end
    end

endmodule

// File: rtl/dnn_argmax_fix.sv
// Serial argmax over the engine's scores: capture on done rising edge, scan one
// score per cycle, then hold winner / score / top-2 margin until accepted.
module dnn_argmax_fix
    import dnn_fix_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DNN_DATA_WIDTH,
    parameter int unsigned NUM_CLASSES = DNN_NUM_CLASSES,
    parameter int unsigned IDX_WIDTH   = DNN_IDX_WIDTH
) (
    input logic             clk,
    input logic             rst,
    dnn_argmax_fix_if.slave sif
);

    localparam logic signed [DATA_WIDTH-1:0] MinScore = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0]         LastIdx  = IDX_WIDTH'(NUM_CLASSES - 1);

    argmax_state_t state_q, state_d;

    logic done_q;
    logic start_evt;
    logic last;
    logic capture;

    logic signed [DATA_WIDTH-1:0] arr_q [NUM_CLASSES];
    logic        [IDX_WIDTH-1:0]  idx_q;
    logic signed [DATA_WIDTH-1:0] best_q;
    logic signed [DATA_WIDTH-1:0] second_q;
    logic        [IDX_WIDTH-1:0]  best_idx_q;

    logic signed [DATA_WIDTH-1:0] cur_score;
    logic signed [DATA_WIDTH-1:0] best_next;
    logic signed [DATA_WIDTH-1:0] second_next;
    logic        [IDX_WIDTH-1:0]  best_idx_next;
    logic        [DATA_WIDTH:0]   margin_next;

    logic        [IDX_WIDTH-1:0]  class_idx_q;
    logic        [DATA_WIDTH-1:0] class_score_q;
    logic        [DATA_WIDTH:0]   margin_q;

    assign start_evt = sif.scores_done & ~done_q;
    assign last      = (idx_q == LastIdx);
    assign capture   = (state_q == IDLE) & start_evt & ~sif.clear;
    assign cur_score = arr_q[idx_q];

    dnn_top2_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_top2 (
        .s             (cur_score),
        .best          (best_q),
        .second        (second_q),
        .best_idx      (best_idx_q),
        .idx           (idx_q),
        .best_next     (best_next),
        .second_next   (second_next),
        .best_idx_next (best_idx_next)
    );

    // best >= second always holds, so the sign-extended difference is non-negative.
    assign margin_next = {best_next[DATA_WIDTH-1], best_next}
                       - {second_next[DATA_WIDTH-1], second_next};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every other event.
    always_comb begin
        state_d = state_q;
        if (sif.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_evt) state_d = SCAN;
                SCAN:    if (last) state_d = HOLD;
                HOLD:    if (sif.result_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Done edge detector; tracks the level in every state so a held level never retriggers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else if (sif.clear) begin
            done_q <= 1'b0;
        end else begin
            done_q <= sif.scores_done;
        end
    end

    // Score buffer; only read after a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                arr_q[i] <= sif.scores[i];
            end
        end
    end

    // Scan datapath and registered result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q         <= '0;
            best_q        <= MinScore;
            second_q      <= MinScore;
            best_idx_q    <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            margin_q      <= '0;
        end else if (sif.clear) begin
            idx_q         <= '0;
            best_q        <= MinScore;
            second_q      <= MinScore;
            best_idx_q    <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            margin_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_evt) begin
                        idx_q      <= '0;
                        best_q     <= MinScore;
                        second_q   <= MinScore;
                        best_idx_q <= '0;
                    end
                end
                SCAN: begin
                    best_q     <= best_next;
                    second_q   <= second_next;
                    best_idx_q <= best_idx_next;
                    idx_q      <= idx_q + IDX_WIDTH'(1);
                    if (last) begin
                        class_idx_q   <= best_idx_next;
                        class_score_q <= best_next;
                        margin_q      <= margin_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sif.busy         = (state_q != IDLE);
    assign sif.result_valid = (state_q == HOLD);
    assign sif.class_idx    = class_idx_q;
    assign sif.class_score  = class_score_q;
    assign sif.margin       = margin_q;

endmodule

// File: tb/tb_dnn_argmax_fix.sv
// Bench for dnn_argmax_fix: table vectors, random vectors, backpressure, clear and reset.
module tb_dnn_argmax_fix;

    localparam int DW = 14;
    localparam int NC = 10;
    localparam int IW = 4;

    typedef logic [NC-1:0][DW-1:0] scores_t;

    typedef struct {
        scores_t s;
        int      idx;
        int      score;
        int      margin;
    } vec_t;

    typedef struct {
        int idx;
        int score;
        int margin;
    } exp_t;

    logic clk;
    logic rst;

    dnn_argmax_fix_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) sif ();

    dnn_argmax_fix #(
        .DATA_WIDTH  (DW),
        .NUM_CLASSES (NC),
        .IDX_WIDTH   (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic scores_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        int      a[NC];
        scores_t r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
        for (int i = 0; i < NC; i++) r[i] = DW'(a[i]);
        return r;
    endfunction

    // Reference: max value, lowest index holding it, then max over all other indices.
    function automatic exp_t model(input scores_t s);
        logic signed [DW-1:0] t;
        int   v[NC];
        int   mx;
        int   sec;
        exp_t e;
        for (int i = 0; i < NC; i++) begin
            t    = s[i];
            v[i] = int'(t);
        end
        mx = v[0];
        for (int i = 1; i < NC; i++) if (v[i] > mx) mx = v[i];
        e.idx = -1;
        for (int i = NC - 1; i >= 0; i--) if (v[i] == mx) e.idx = i;
        sec = -(1 << (DW - 1));
        for (int i = 0; i < NC; i++) if (i != e.idx && v[i] > sec) sec = v[i];
        e.score  = mx;
        e.margin = mx - sec;
        return e;
    endfunction

    // Scoreboard: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && sif.result_valid && sif.result_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got class %0d with no result pending",
                         sif.class_idx);
            end else begin
                e = sb.pop_front();
                chk("class_idx", int'(sif.class_idx), e.idx);
                chk("class_score", int'($signed(sif.class_score)), e.score);
                chk("margin", int'(sif.margin), e.margin);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(sif.busy), 0);
        chk({tag, "_valid"}, int'(sif.result_valid), 0);
        chk({tag, "_idx"}, int'(sif.class_idx), 0);
        chk({tag, "_score"}, int'(sif.class_score), 0);
        chk({tag, "_margin"}, int'(sif.margin), 0);
    endtask

    // Raise done with the given scores; return just after the capture edge with
    // done dropped and the score bus scrambled.
    task automatic start_run(input scores_t s);
        @(posedge clk);
        #2;
        sif.scores      = s;
        sif.scores_done = 1'b1;
        @(posedge clk);
        #2;
        sif.scores_done = 1'b0;
        sif.scores      = {NC{14'h1fff}};
    endtask

    // Counts posedges from the capture edge (=1) until valid is seen.
    task automatic wait_valid(output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (sif.result_valid) break;
            if (n >= 40) begin
                n = -1;
                break;
            end
            @(posedge clk);
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        int   lat;
        e.idx    = v.idx;
        e.score  = v.score;
        e.margin = v.margin;
        sb.push_back(e);
        start_run(v.s);
        wait_valid(lat);
        // Done seen in cycle T, result valid in cycle T+11.
        chk({name, "_latency"}, lat, 11);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid_one_cycle"}, int'(sif.result_valid), 0);
        chk({name, "_idle_after"}, int'(sif.busy), 0);
    endtask

    initial begin
        vec_t    v;
        exp_t    e;
        scores_t s;
        int      lat;

        tbl[0] = '{mk(10, -5, 300, 7, 299, 0, 1, 2, 3, 4), 2, 300, 1};
        tbl[1] = '{mk(-100, -90, -80, -8192, -70, -60, -75, -61, -200, -65), 5, -60, 1};
        tbl[2] = '{mk(0, 50, 50, 0, 0, 0, 0, 0, 0, 0), 1, 50, 0};
        tbl[3] = '{mk(123, 123, 123, 123, 123, 123, 123, 123, 123, 123), 0, 123, 0};
        tbl[4] = '{mk(-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, 8191),
                   9, 8191, 16383};
        tbl[5] = '{mk(-1, -2, -3, -4, -5, -6, -7, -8, -9, -10), 0, -1, 1};
        tbl[6] = '{mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 7), 0, 7, 0};

        rst              = 1'b0;
        sif.clear        = 1'b0;
        sif.scores_done  = 1'b0;
        sif.result_ready = 1'b1;
        sif.scores       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_zero("after_reset");

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Small value range forces frequent ties.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NC; i++) s[i] = DW'(int'($urandom_range(8)) - 4);
            e = model(s);
            v = '{s, e.idx, e.score, e.margin};
            run_vec(v, $sformatf("rand%0d", r));
        end

        // Backpressure with a second done pulse during HOLD.
        sif.result_ready = 1'b0;
        e.idx    = 5;
        e.score  = 64;
        e.margin = 22;
        sb.push_back(e);
        start_run(mk(20, -3, 42, 17, -900, 64, 33, 0, -99, 12));
        wait_valid(lat);
        chk("bp_latency", lat, 11);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #2;
            if (c == 5) begin
                sif.scores      = mk(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000);
                sif.scores_done = 1'b1;
            end
            @(negedge clk);
            chk("bp_valid", int'(sif.result_valid), 1);
            chk("bp_idx", int'(sif.class_idx), 5);
            chk("bp_score", int'($signed(sif.class_score)), 64);
            chk("bp_margin", int'(sif.margin), 22);
        end
        @(posedge clk);
        #2;
        sif.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_drop", int'(sif.result_valid), 0);
        // done level is still high: it must not retrigger.
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk("bp_no_retrigger", int'(sif.busy), 0);
        end
        sif.scores_done = 1'b0;
        chk("bp_outputs_kept", int'(sif.class_idx), 5);

        // Synchronous clear mid-scan.
        start_run(tbl[0].s);
        repeat (4) @(posedge clk);
        #2;
        sif.clear = 1'b1;
        @(posedge clk);
        #2;
        sif.clear = 1'b0;
        check_zero("clear");
        repeat (15) @(negedge clk);
        chk("clear_stays_idle", int'(sif.busy), 0);

        // Full run to leave non-zero outputs, then async reset mid-scan.
        run_vec(tbl[0], "pre_rst");
        start_run(tbl[1].s);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        run_vec(tbl[4], "post_rst");

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
